// File: rtl/pkt_bus_pkg.sv
// ----------------------------------------------------------------------------
// pkt_bus_pkg
// Shared definitions for the 134-bit internal packet bus:
//   - word type codes (head / middle / tail) and bus geometry
//   - metadata prefix size and payload length limits
//   - generator FSM state encoding
//   - helpers that turn a configured payload length into frame length,
//     word count and tail invalid-byte count
// ----------------------------------------------------------------------------
package pkt_bus_pkg;

    localparam int          BUS_W       = 134;
    localparam logic [1:0]  TYPE_HEAD   = 2'b01;
    localparam logic [1:0]  TYPE_MID    = 2'b11;
    localparam logic [1:0]  TYPE_TAIL   = 2'b10;
    localparam int          MD_BYTES    = 32;
    localparam int          LEN_LSB     = 96;
    localparam int          LEN_MSB     = 107;
    localparam logic [11:0] PAYLOAD_MIN = 12'd60;
    localparam logic [11:0] PAYLOAD_MAX = 12'd1514;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_HEAD = 3'd2,
        S_MD   = 3'd3,
        S_BODY = 3'd4,
        S_GAP  = 3'd5
    } gen_state_t;

    // Frame length in bytes: clamped payload plus the metadata prefix.
    function automatic logic [11:0] frame_len(input logic [11:0] cfg_len);
        logic [11:0] p;
        if (cfg_len < PAYLOAD_MIN) begin
            p = PAYLOAD_MIN;
        end else if (cfg_len > PAYLOAD_MAX) begin
            p = PAYLOAD_MAX;
        end else begin
            p = cfg_len;
        end
        return p + 12'(MD_BYTES);
    endfunction

    // Number of 16-byte bus words needed to carry len bytes (6..97).
    function automatic logic [6:0] frame_words(input logic [11:0] len);
        logic [12:0] t;
        t = {1'b0, len} + 13'd15;
        return t[10:4];
    endfunction

    // Unused bytes in the last word: (16 - len mod 16) mod 16.
    function automatic logic [3:0] tail_inv(input logic [11:0] len);
        return 4'd0 - len[3:0];
    endfunction

endpackage

// File: rtl/pkt_gen_if.sv
// ----------------------------------------------------------------------------
// pkt_gen_if
// Packet bus between the generator (master) and the pipeline ingress FIFO
// (slave).
//   out_data      134-bit bus word
//   out_data_wr   out_data qualifier
//   out_valid     packet-good flag, qualified by out_valid_wr
//   out_valid_wr  one-cycle pulse with each tail word
//   in_alf        downstream almost-full (slave -> master)
// ----------------------------------------------------------------------------
interface pkt_gen_if;
    import pkt_bus_pkg::*;

    logic [BUS_W-1:0] out_data;
    logic             out_data_wr;
    logic             out_valid;
    logic             out_valid_wr;
    logic             in_alf;

    modport master (
        output out_data,
        output out_data_wr,
        output out_valid,
        output out_valid_wr,
        input  in_alf
    );

    modport slave (
        input  out_data,
        input  out_data_wr,
        input  out_valid,
        input  out_valid_wr,
        output in_alf
    );

endinterface

// File: rtl/pkt_gen_word.sv
// ----------------------------------------------------------------------------
// pkt_gen_word
// Combinational bus-word formatter for the packet generator.
//   state     generator FSM state (only HEAD/MD/BODY produce a word)
//   k         word index within the frame
//   w         words per frame
//   l         frame length in bytes (payload + metadata)
//   seq       packet sequence number
//   out_data  formatted 134-bit word (all zero outside HEAD/MD/BODY)
// ----------------------------------------------------------------------------
module pkt_gen_word
    import pkt_bus_pkg::*;
(
    input  gen_state_t       state,
    input  logic [6:0]       k,
    input  logic [6:0]       w,
    input  logic [11:0]      l,
    input  logic [31:0]      seq,
    output logic [BUS_W-1:0] out_data
);

    // Build the word for the current frame position.
    always_comb begin
        out_data = '0;
        case (state)
            S_HEAD: begin
                out_data[133:132]         = TYPE_HEAD;
                out_data[LEN_MSB:LEN_LSB] = l;
            end
            S_MD: begin
                out_data[133:132] = TYPE_MID;
                out_data[31:0]    = seq;
            end
            S_BODY: begin
                if (k == (w - 7'd1)) begin
                    out_data[133:132] = TYPE_TAIL;
                    out_data[131:128] = tail_inv(l);
                end else begin
                    out_data[133:132] = TYPE_MID;
                end
                out_data[127:96] = seq;
                out_data[95:80]  = {9'd0, k};
            end
            default: begin
                out_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/pkt_gen.sv
// ----------------------------------------------------------------------------
// pkt_gen
// Software-controlled test packet generator driving the internal packet bus.
// A run starts on a start pulse (config latched then), emits cfg_pkt_num
// frames (0 = until stop) separated by cfg_gap idle cycles, and keeps
// sent-packet / sent-payload-bit counters for TX/RX cross-checking.
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle run start, ignored while a run is active
//   stop            level: finish the current frame, then go idle
//   reset_reg       synchronous counter clear, wins over a same-cycle update
//   cfg_pkt_len     payload bytes per frame (clamped to 60..1514)
//   cfg_pkt_num     frames per run, 0 = continuous
//   cfg_gap         idle cycles after each tail
//   bus             packet bus master port (data, qualifiers, in_alf)
//   busy            run in progress, aligned with the emitted words
//   tx_pkt_cnt      frames completed
//   tx_bit_cnt      payload bits sent
// ----------------------------------------------------------------------------
module pkt_gen
    import pkt_bus_pkg::*;
#(
    parameter string PLATFORM = "Xilinx-OpenBox-S4"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        reset_reg,
    input  logic [11:0] cfg_pkt_len,
    input  logic [31:0] cfg_pkt_num,
    input  logic [7:0]  cfg_gap,
    pkt_gen_if.master   bus,
    output logic        busy,
    output logic [63:0] tx_pkt_cnt,
    output logic [63:0] tx_bit_cnt
);

    gen_state_t       state_q, state_d;
    logic [11:0]      len_q, len_d;
    logic [6:0]       w_q, w_d;
    logic [31:0]      num_q, num_d;
    logic [7:0]       gap_q, gap_d;
    logic [31:0]      seq_q, seq_d;
    logic [6:0]       k_q, k_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;

    logic [BUS_W-1:0] out_data_q;
    logic             out_data_wr_q;
    logic             out_valid_q;
    logic             out_valid_wr_q;
    logic             busy_q;
    logic [63:0]      pkt_cnt_q;
    logic [63:0]      bit_cnt_q;

    logic [11:0]      start_len_s;
    logic             tail_s;
    logic             last_s;
    logic             active_s;
    logic [BUS_W-1:0] word_s;

    assign start_len_s = frame_len(cfg_pkt_len);
    assign tail_s      = (state_q == S_BODY) && (k_q == (w_q - 7'd1));
    // seq counts completed frames of this run, so it doubles as run count.
    assign last_s      = (num_q != 32'd0) && ((seq_q + 32'd1) == num_q);
    assign active_s    = (state_q == S_HEAD) || (state_q == S_MD) || (state_q == S_BODY);

    pkt_gen_word u_word (
        .state    (state_q),
        .k        (k_q),
        .w        (w_q),
        .l        (len_q),
        .seq      (seq_q),
        .out_data (word_s)
    );

    // Next-state and run-parameter logic.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        w_d       = w_q;
        num_d     = num_q;
        gap_d     = gap_q;
        seq_d     = seq_q;
        k_d       = k_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    len_d   = start_len_s;
                    w_d     = frame_words(start_len_s);
                    num_d   = cfg_pkt_num;
                    gap_d   = cfg_gap;
                    seq_d   = 32'd0;
                    k_d     = 7'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // in_alf only gates the start of a frame.
                if (stop) begin
                    state_d = S_IDLE;
                end else if (!bus.in_alf) begin
                    state_d = S_HEAD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HEAD: begin
                state_d = S_MD;
                k_d     = 7'd1;
            end
            S_MD: begin
                state_d = S_BODY;
                k_d     = 7'd2;
            end
            S_BODY: begin
                if (tail_s) begin
                    seq_d = seq_q + 32'd1;
                    k_d   = 7'd0;
                    if (stop || last_s) begin
                        state_d = S_IDLE;
                    end else if (gap_q != 8'd0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_q - 8'd1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    k_d = k_q + 7'd1;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (gap_cnt_q == 8'd0) begin
                    state_d = S_WAIT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and run-parameter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= 12'd0;
            w_q       <= 7'd0;
            num_q     <= 32'd0;
            gap_q     <= 8'd0;
            seq_q     <= 32'd0;
            k_q       <= 7'd0;
            gap_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            w_q       <= w_d;
            num_q     <= num_d;
            gap_q     <= gap_d;
            seq_q     <= seq_d;
            k_q       <= k_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Output registers: words trail the FSM state by one cycle, and busy is
    // delayed the same way so it frames exactly the emitted words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q     <= '0;
            out_data_wr_q  <= 1'b0;
            out_valid_q    <= 1'b0;
            out_valid_wr_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            out_data_q     <= word_s;
            out_data_wr_q  <= active_s;
            out_valid_q    <= tail_s;
            out_valid_wr_q <= tail_s;
            busy_q         <= (state_q != S_IDLE);
        end
    end

    // TX counters: updated on the edge after the tail is on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q <= 64'd0;
            bit_cnt_q <= 64'd0;
        end else if (reset_reg) begin
            pkt_cnt_q <= 64'd0;
            bit_cnt_q <= 64'd0;
        end else if (out_valid_wr_q) begin
            pkt_cnt_q <= pkt_cnt_q + 64'd1;
            bit_cnt_q <= bit_cnt_q + {49'd0, len_q - 12'(MD_BYTES), 3'b000};
        end else begin
            pkt_cnt_q <= pkt_cnt_q;
            bit_cnt_q <= bit_cnt_q;
        end
    end

    assign bus.out_data     = out_data_q;
    assign bus.out_data_wr  = out_data_wr_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_valid_wr = out_valid_wr_q;
    assign busy             = busy_q;
    assign tx_pkt_cnt       = pkt_cnt_q;
    assign tx_bit_cnt       = bit_cnt_q;

endmodule

// File: tb/tb_pkt_gen.sv
// ----------------------------------------------------------------------------
// tb_pkt_gen
// Self-checking bench for pkt_gen. A reference model builds the expected
// frame words, their timing and the TX counters from the frame rules, and
// everything captured on the bus is compared against it.
// ----------------------------------------------------------------------------
module tb_pkt_gen;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        start       = 1'b0;
    logic        stop        = 1'b0;
    logic        reset_reg   = 1'b0;
    logic [11:0] cfg_pkt_len = 12'd0;
    logic [31:0] cfg_pkt_num = 32'd0;
    logic [7:0]  cfg_gap     = 8'd0;
    logic        busy;
    logic [63:0] tx_pkt_cnt;
    logic [63:0] tx_bit_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic [133:0] cap_w[$];
    int           cap_t[$];
    bit           cap_tail[$];

    longint unsigned exp_pkts = 0;
    longint unsigned exp_bits = 0;
    int              cur_p    = 0;

    pkt_gen_if bus();

    pkt_gen #(.PLATFORM("Xilinx-OpenBox-S4")) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .reset_reg   (reset_reg),
        .cfg_pkt_len (cfg_pkt_len),
        .cfg_pkt_num (cfg_pkt_num),
        .cfg_gap     (cfg_gap),
        .bus         (bus.master),
        .busy        (busy),
        .tx_pkt_cnt  (tx_pkt_cnt),
        .tx_bit_cnt  (tx_bit_cnt)
    );

    always #5 clk = ~clk;

    // Edge counter used to timestamp bus words.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected word k of frame number seq, straight from the framing rules.
    function automatic logic [133:0] exp_word(input int l, input int w, input int k, input int seq);
        logic [133:0] x;
        x = '0;
        if (k == 0) begin
            x[133:132] = 2'b01;
            x[107:96]  = l[11:0];
        end else begin
            x[133:132] = (k == w - 1) ? 2'b10 : 2'b11;
            if (k == w - 1) x[131:128] = 4'((16 - (l % 16)) % 16);
            if (k == 1) begin
                x[31:0] = seq;
            end else begin
                x[127:96] = seq;
                x[95:80]  = k[15:0];
            end
        end
        return x;
    endfunction

    // Bus monitor: capture words, check tail qualifiers and pre-update counters.
    always @(negedge clk) begin
        if (rst_n && bus.out_data_wr) begin
            cap_w.push_back(bus.out_data);
            cap_t.push_back(cyc);
            cap_tail.push_back(bus.out_valid_wr);
        end
        if (rst_n && bus.out_valid_wr) begin
            chk_val("valid_with_tail", bus.out_valid, 1);
            chk_val("busy_at_tail", busy, 1);
            chk_val("pkt_cnt_before_tail", tx_pkt_cnt, exp_pkts);
            chk_val("bit_cnt_before_tail", tx_bit_cnt, exp_bits);
            exp_pkts = exp_pkts + 1;
            exp_bits = exp_bits + 64'(cur_p) * 8;
        end
    end

    task automatic run(input int len, input int num, input int gap, input int alf_hold,
                       input bit do_stop, input bit do_clr);
        int p, l, w, npk, ts, first_head, wait_cnt, idx;
        p   = (len < 60) ? 60 : ((len > 1514) ? 1514 : len);
        l   = p + 32;
        w   = (l + 15) / 16;
        npk = (num == 0) ? 1 : num;
        cur_p = p;
        cap_w.delete();
        cap_t.delete();
        cap_tail.delete();
        @(negedge clk);
        cfg_pkt_len = len[11:0];
        cfg_pkt_num = num;
        cfg_gap     = gap[7:0];
        bus.in_alf  = (alf_hold > 0);
        start       = 1'b1;
        ts          = cyc + 1;
        first_head  = ts + 2;
        @(negedge clk);
        start = 1'b0;
        if (alf_hold > 0) begin
            repeat (alf_hold - 1) @(negedge clk);
            chk_val("alf_blocks_head", cap_w.size(), 0);
            bus.in_alf = 1'b0;
            first_head = cyc + 2;
        end
        wait_cnt = 0;
        while ((busy || cyc < ts + 2) && wait_cnt < 5000) begin
            @(negedge clk);
            #1;
            wait_cnt++;
            if (alf_hold > 0 && cap_w.size() == 3) bus.in_alf = 1'b1;
            if (do_stop && cap_w.size() >= 4) stop = 1'b1;
            reset_reg = (do_clr && bus.out_valid_wr);
        end
        chk_val("run_timeout", (wait_cnt >= 5000), 0);
        stop       = 1'b0;
        reset_reg  = 1'b0;
        bus.in_alf = 1'b0;
        if (do_clr) begin
            exp_pkts = 0;
            exp_bits = 0;
        end
        chk_val($sformatf("word_count len=%0d", len), cap_w.size(), npk * w);
        if (cap_w.size() == npk * w) begin
            chk_val("busy_drop_after_tail", cyc, cap_t[npk * w - 1] + 1);
            for (int pk = 0; pk < npk; pk++) begin
                for (int k = 0; k < w; k++) begin
                    idx = pk * w + k;
                    chk_val($sformatf("word p%0d k%0d", pk, k), cap_w[idx], exp_word(l, w, k, pk));
                    chk_val($sformatf("tail_flag p%0d k%0d", pk, k), cap_tail[idx], (k == w - 1));
                    if (k == 0) begin
                        chk_val($sformatf("head_time p%0d", pk), cap_t[idx],
                                (pk == 0) ? first_head : cap_t[idx - 1] + gap + 2);
                    end else begin
                        chk_val($sformatf("word_time p%0d k%0d", pk, k), cap_t[idx], cap_t[idx - 1] + 1);
                    end
                end
            end
        end
        chk_val("tx_pkt_cnt", tx_pkt_cnt, exp_pkts);
        chk_val("tx_bit_cnt", tx_bit_cnt, exp_bits);
    endtask

    initial begin
        bus.in_alf = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("rst_out_data", bus.out_data, 0);
        chk_val("rst_out_data_wr", bus.out_data_wr, 0);
        chk_val("rst_out_valid", bus.out_valid, 0);
        chk_val("rst_out_valid_wr", bus.out_valid_wr, 0);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_pkt_cnt", tx_pkt_cnt, 0);
        chk_val("rst_bit_cnt", tx_bit_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_val("idle_busy", busy, 0);

        run(64, 1, 0, 0, 1'b0, 1'b0);
        chk_val("len64_bits", tx_bit_cnt, 512);
        run(65, 1, 0, 0, 1'b0, 1'b0);
        chk_val("len65_bits", tx_bit_cnt, 512 + 520);
        run(64, 1, 0, 10, 1'b0, 1'b0);
        run(60, 3, 2, 0, 1'b0, 1'b0);
        run(10, 1, 1, 0, 1'b0, 1'b0);
        run(4000, 1, 0, 0, 1'b0, 1'b0);
        run(100, 0, 0, 0, 1'b1, 1'b0);
        run(200, 1, 0, 0, 1'b0, 1'b1);
        chk_val("clr_pkt_zero", tx_pkt_cnt, 0);
        chk_val("clr_bit_zero", tx_bit_cnt, 0);

        for (int i = 0; i < 6; i++) begin
            run($urandom_range(0, 1700), $urandom_range(1, 3), $urandom_range(0, 4), 0, 1'b0, 1'b0);
        end

        // Reset in the middle of a frame truncates it at once.
        @(negedge clk);
        cfg_pkt_len = 12'd300;
        cfg_pkt_num = 32'd1;
        cfg_gap     = 8'd0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_val("midrst_data_wr", bus.out_data_wr, 0);
        chk_val("midrst_busy", busy, 0);
        chk_val("midrst_pkt_cnt", tx_pkt_cnt, 0);
        exp_pkts = 0;
        exp_bits = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_val("post_rst_data_wr", bus.out_data_wr, 0);
        run(70, 2, 1, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pkt_gen.md
# pkt_gen

Software-controlled test packet generator that drives the 134-bit internal packet bus (head/middle/tail framing, 32-byte metadata prefix) into the pipeline. It is the transmit-side counterpart of the statistics monitor: it emits well-formed frames whose length field and framing are exactly what the monitor counts. It also keeps its own sent-packet and sent-bit counters so software can cross-check TX against RX. It sits between the control-register block (lcm) and the pipeline ingress FIFO.

## Interface
- PLATFORM, "Xilinx-OpenBox-S4", target platform tag; no functional effect.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; samples cfg_* and begins a run; ignored while busy=1.
- stop  in  1  level; finish current packet, then return to IDLE.
- reset_reg  in  1  software counter clear, synchronous, level.
- cfg_pkt_len  in  12  payload bytes per packet, excluding metadata; clamped to 60..1514.
- cfg_pkt_num  in  32  packets per run; 0 = continuous until stop.
- cfg_gap  in  8  idle cycles after each tail.
- in_alf  in  1  downstream almost-full; gates packet start only.
- out_data  out  134  bus word: [133:132] type (01 head, 11 middle, 10 tail), [131:128] invalid-byte count, [127:0] data.
- out_data_wr  out  1  out_data qualifier.
- out_valid  out  1  packet-good flag, always 1 when out_valid_wr=1.
- out_valid_wr  out  1  one-cycle pulse with each tail word.
- busy  out  1  run in progress (state != IDLE).
- tx_pkt_cnt  out  64  packets completed.
- tx_bit_cnt  out  64  payload bits sent, i.e. (L-32)*8 per packet.

## Operation
- Run parameters are latched on an accepted start. P = clamp(cfg_pkt_len, 60, 1514), L = P+32, W = ceil(L/16). W is 6..97.
- Seq is a 32-bit packet sequence number. It is 0 at run start, increments after each tail, and wraps at 2^32.
- Word 0 (head, type 01): [107:96]=L, all other data bits 0.
- Word 1 (middle, metadata 2): [31:0]=seq, rest 0.
- Words 2..W-1 (payload): [127:96]=seq, [95:80]=word index k, rest 0. The last word is type 10, all others type 11.
- [131:128]=0 on every non-tail word. On the tail, [131:128]=(16-L mod 16) mod 16.
- States:
  - IDLE -> WAIT on accepted start.
  - WAIT -> HEAD when in_alf=0 and stop=0. WAIT -> IDLE if stop=1.
  - HEAD -> MD -> BODY. BODY holds for W-2 cycles.
  - On tail: -> IDLE if stop=1 or the run count is reached; else -> GAP if cfg_gap>0; else -> WAIT.
  - GAP counts cfg_gap cycles, then -> WAIT, or -> IDLE if stop=1.
- in_alf is ignored once HEAD is issued; a packet is never split or stalled.
- On each tail cycle the counters update: tx_pkt_cnt+=1 and tx_bit_cnt+=(L-32)*8. The arithmetic is 64-bit, zero-extended, with no saturation.
- reset_reg=1 holds both counters at 0 and takes priority over a same-cycle tail update. It does not affect the FSM.

## Timing
- Reset values: every output is 0, FSM is IDLE, seq is 0.
- All outputs are registered.
- With in_alf=0, start at edge t produces the head at edge t+2 (WAIT occupies one cycle). Word k appears at t+2+k, with no bubbles.
- out_valid_wr and out_valid assert in the same cycle as the tail.
- Counter values change at the edge after the tail cycle.
- Back-to-back packets with cfg_gap=G: the next head follows the previous tail by G+2 cycles, provided in_alf=0.
- If stop asserts during a packet, the remaining words are still emitted and busy drops the cycle after the tail.
- If rst_n asserts mid-packet, the output stops immediately with no tail. This is an accepted truncation; downstream treats it as an error packet.

## Structure
- Shared package (pkt_bus_pkg) holds: the type codes HEAD=2'b01, MID=2'b11, TAIL=2'b10; MD_BYTES=32; bus width 134; length field bits [107:96]; min/max payload constants 60 and 1514.
- Sub-module pkt_gen_word holds the combinational word formatter. Inputs: state, k, W, L, seq. Output: out_data. The FSM, counters and run counter stay in pkt_gen.

## Test plan
- cfg_pkt_len=64, num=1, in_alf=0: 6 words with types 01,11,11,11,11,10; head [107:96]=96; tail inv=0; tx_pkt_cnt=1, tx_bit_cnt=512.
- cfg_pkt_len=65: L=97, W=7, tail inv=15, tx_bit_cnt=520.
- in_alf=1 held for 10 cycles after start: no out_data_wr. After in_alf drops, the head appears 1 cycle later. Raising in_alf mid-packet does not stall the packet.
- num=3, gap=2, len=60: exactly 2 idle cycles between each tail and the next head; payload [127:96]=0,1,2 for the three packets; busy drops after the 3rd tail.
- cfg_pkt_len=10 and cfg_pkt_len=4000 clamp to L=92 (W=6, inv=4) and L=1546 (W=97, inv=6).
- num=0 with stop asserted on word 3: the packet completes, with no further head. Then reset_reg pulses coincident with a tail: both counters read 0 afterwards.
